// File: rtl/four_bit_full_adder.sv
// Registered ripple-carry adder: A + B + cin -> {cout, S}, with signed overflow
// and zero flags, all captured on the rising clock edge.
module four_bit_full_adder #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] S,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_cell
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  // Load-enable mux: hold the current result unless en is asserted.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (en) begin
      s_d    = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = (s == '0);
    end
  end

  // Reset has priority over the load, even with en high in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed and exhaustive checks of the registered adder at WIDTH=2 and WIDTH=4.
module tb_four_bit_full_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] a2, b2;
  logic       cin2;
  logic [1:0] s2;
  logic       cout2, ovf2, zero2;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] s4;
  logic       cout4, ovf4, zero4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  four_bit_full_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en),
    .A(a2), .B(b2), .cin(cin2),
    .cout(cout2), .S(s2), .ovf(ovf2), .zero(zero2)
  );

  four_bit_full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en),
    .A(a4), .B(b4), .cin(cin4),
    .cout(cout4), .S(s4), .ovf(ovf4), .zero(zero4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] obs_s, input logic obs_c,
                           input logic obs_o, input logic obs_z, input logic [31:0] exp_s,
                           input logic exp_c, input logic exp_o, input logic exp_z);
    check_eq({tag, ".S"}, obs_s, exp_s);
    check_eq({tag, ".cout"}, 32'(obs_c), 32'(exp_c));
    check_eq({tag, ".ovf"}, 32'(obs_o), 32'(exp_o));
    check_eq({tag, ".zero"}, 32'(obs_z), 32'(exp_z));
  endtask

  // Independent model: wide integer add, overflow from operand/result signs.
  task automatic check_model(input string tag, input int w, input logic [31:0] a,
                             input logic [31:0] b, input logic ci, input logic [31:0] obs_s,
                             input logic obs_c, input logic obs_o, input logic obs_z);
    logic [32:0] sum;
    logic [31:0] mask, es;
    logic        ec, eo;
    sum  = 33'(a) + 33'(b) + 33'(ci);
    mask = (32'd1 << w) - 32'd1;
    es   = sum[31:0] & mask;
    ec   = sum[w];
    eo   = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
    check_out(tag, obs_s, obs_c, obs_o, obs_z, es, ec, eo, es == 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    a2 = a; b2 = b; cin2 = ci;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1;
    drive2(2'd3, 2'd3, 1'b0);
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    tick();
    check_out("rst_w2", 32'(s2), cout2, ovf2, zero2, 32'd0, 1'b0, 1'b0, 1'b1);
    check_out("rst_w4", 32'(s4), cout4, ovf4, zero4, 32'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    drive2(2'd0, 2'd0, 1'b0); tick();
    check_out("0+0+0", 32'(s2), cout2, ovf2, zero2, 32'd0, 1'b0, 1'b0, 1'b1);
    drive2(2'd3, 2'd3, 1'b0); tick();
    check_out("3+3+0", 32'(s2), cout2, ovf2, zero2, 32'd2, 1'b1, 1'b0, 1'b0);
    drive2(2'd1, 2'd1, 1'b0); tick();
    check_out("1+1+0", 32'(s2), cout2, ovf2, zero2, 32'd2, 1'b0, 1'b1, 1'b0);
    drive2(2'd3, 2'd0, 1'b1); tick();
    check_out("3+0+1", 32'(s2), cout2, ovf2, zero2, 32'd0, 1'b1, 1'b0, 1'b1);
    drive2(2'd3, 2'd3, 1'b1); tick();
    check_out("3+3+1", 32'(s2), cout2, ovf2, zero2, 32'd3, 1'b1, 1'b0, 1'b0);

    // Changed inputs with en low must not disturb the held result.
    en = 1'b0;
    drive2(2'd1, 2'd1, 1'b0); tick();
    check_out("hold", 32'(s2), cout2, ovf2, zero2, 32'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("hold2", 32'(s2), cout2, ovf2, zero2, 32'd3, 1'b1, 1'b0, 1'b0);

    en = 1'b1; reset = 1'b1;
    drive2(2'd3, 2'd3, 1'b1); tick();
    check_out("rst_en", 32'(s2), cout2, ovf2, zero2, 32'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      drive2(v[4:3], v[2:1], v[0]);
      tick();
      check_model("sweep_w2", 2, 32'(v[4:3]), 32'(v[2:1]), v[0], 32'(s2), cout2, ovf2, zero2);
    end

    a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1; tick();
    check_out("15+15+1", 32'(s4), cout4, ovf4, zero4, 32'd15, 1'b1, 1'b0, 1'b0);
    a4 = 4'd7; b4 = 4'd1; cin4 = 1'b0; tick();
    check_out("7+1+0", 32'(s4), cout4, ovf4, zero4, 32'd8, 1'b0, 1'b1, 1'b0);
    a4 = 4'd8; b4 = 4'd8; cin4 = 1'b0; tick();
    check_out("8+8+0", 32'(s4), cout4, ovf4, zero4, 32'd0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
      tick();
      check_model("sweep_w4", 4, 32'(v[8:5]), 32'(v[4:1]), v[0], 32'(s4), cout4, ovf4, zero4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
